snapshot_rx: RTL and testbench

SNAPSHOT_RX -- requirements
Module: snapshot_rx

---
 rtl/crc16.sv | 16 +
 rtl/snapshot_rx.sv | 125 ++++++++++++
 tb/tb_snapshot_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/crc16.sv
// Byte-wide CRC-16 (poly 0x1021, init supplied by caller), data bit 0 processed first.
module crc16 (
  input  logic [15:0] crcIn,
  input  logic [7:0]  data,
  output logic [15:0] crcOut
);

  always_comb begin
    crcOut = crcIn;
    for (int i = 0; i < 8; i++) begin
      if (crcOut[15] ^ data[i]) crcOut = {crcOut[14:0], 1'b0} ^ 16'h1021;
      else                      crcOut = {crcOut[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/snapshot_rx.sv
// Serial LSB-first snapshot frame receiver: payload + 16-bit CRC, length checking.
// Optional frame statistics counters enabled by defining SNAPSHOT_RX_STATS_EN.
module snapshot_rx #(
  parameter int unsigned SAMPLE_WIDTH   = 16,
  parameter int unsigned NUM_TAPS       = 10,
  parameter int unsigned ABS_TIME_WIDTH = 32,
  parameter int unsigned SS_BUFF_SZ     = SAMPLE_WIDTH*NUM_TAPS+ABS_TIME_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pdw_data,
  input  logic                  pdw_frame,
  output logic [SS_BUFF_SZ-1:0] ss_buff,
  output logic                  ss_valid,
  output logic                  crc_ok,
  output logic                  len_err,
  output logic [15:0]           good_cnt,
  output logic [15:0]           err_cnt
);

  localparam int unsigned FRAME_LEN = SS_BUFF_SZ + 16;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {IDLE, PAYLOAD, CRC, CHECK, DRAIN} state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [SS_BUFF_SZ-1:0] shadow;
  logic [15:0]           crc;
  logic [15:0]           crc_next;
  logic [15:0]           rx_crc;
  logic                  frame_q;

  // Top 7 shadow bits are the earlier bits of the byte currently completing.
  crc16 u_crc (
    .crcIn  (crc),
    .data   ({pdw_data, shadow[SS_BUFF_SZ-1 -: 7]}),
    .crcOut (crc_next)
  );

  // frame_q resets high so a frame already in progress at reset release is skipped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shadow   <= '0;
      crc      <= '0;
      rx_crc   <= '0;
      frame_q  <= 1'b1;
      ss_buff  <= '0;
      ss_valid <= 1'b0;
      crc_ok   <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      frame_q  <= pdw_frame;
      ss_valid <= 1'b0;
      len_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pdw_frame && !frame_q) begin
            shadow  <= {pdw_data, shadow[SS_BUFF_SZ-1:1]};
            bit_cnt <= CNT_W'(1);
            crc     <= '0;
            state   <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!pdw_frame) begin
            len_err <= 1'b1;
            state   <= IDLE;
          end else begin
            shadow  <= {pdw_data, shadow[SS_BUFF_SZ-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt[2:0] == 3'd7) crc <= crc_next;
            if (bit_cnt == CNT_W'(SS_BUFF_SZ-1)) state <= CRC;
          end
        end
        CRC: begin
          if (!pdw_frame) begin
            len_err <= 1'b1;
            state   <= IDLE;
          end else begin
            rx_crc  <= {pdw_data, rx_crc[15:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(FRAME_LEN-1)) state <= CHECK;
          end
        end
        CHECK: begin
          ss_buff  <= shadow;
          crc_ok   <= (rx_crc == crc);
          ss_valid <= 1'b1;
          if (pdw_frame) begin
            len_err <= 1'b1;
            state   <= DRAIN;
          end else begin
            state   <= IDLE;
          end
        end
        DRAIN: begin
          if (!pdw_frame) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SNAPSHOT_RX_STATS_EN
  // Saturating counters; an overlong bad-CRC frame counts as a single error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (ss_valid && crc_ok && (good_cnt != 16'hFFFF))
        good_cnt <= good_cnt + 16'd1;
      if (((ss_valid && !crc_ok) || len_err) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign good_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_snapshot_rx.sv
// Scoreboard bench for snapshot_rx: expected outputs queued at stimulus, checked on ss_valid/len_err.
module tb_snapshot_rx;

  localparam int unsigned SS = 192;
`ifdef SNAPSHOT_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic          valid;
    logic          lerr;
    logic          ok;
    logic [SS-1:0] buff;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          pdw_data;
  logic          pdw_frame;
  logic [SS-1:0] ss_buff;
  logic          ss_valid;
  logic          crc_ok;
  logic          len_err;
  logic [15:0]   good_cnt;
  logic [15:0]   err_cnt;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [SS-1:0] last_buff = '0;
  logic          last_ok   = 1'b0;
  int            exp_good  = 0;
  int            exp_err   = 0;

  snapshot_rx dut (
    .clk       (clk),
    .rst       (rst),
    .pdw_data  (pdw_data),
    .pdw_frame (pdw_frame),
    .ss_buff   (ss_buff),
    .ss_valid  (ss_valid),
    .crc_ok    (crc_ok),
    .len_err   (len_err),
    .good_cnt  (good_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [SS-1:0] act, input logic [SS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference CRC: bit-serial over the wire order of the payload.
  function automatic logic [15:0] crc_model(input logic [SS-1:0] p);
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < SS; i++) begin
      if (c[15] ^ p[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [SS+15:0] mk_frame(input logic [SS-1:0] p, input logic [15:0] flip);
    return {crc_model(p) ^ flip, p};
  endfunction

  function automatic logic [SS-1:0] rand_payload();
    logic [SS-1:0] p;
    for (int k = 0; k < SS/32; k++) p[32*k +: 32] = $urandom;
    return p;
  endfunction

  task automatic expect_out(input logic [SS-1:0] p, input logic ok, input logic valid, input logic lerr);
    exp_t e;
    e.valid = valid;
    e.lerr  = lerr;
    e.buff  = valid ? p  : last_buff;
    e.ok    = valid ? ok : last_ok;
    last_buff = e.buff;
    last_ok   = e.ok;
    if (valid && ok) exp_good++;
    if ((valid && !ok) || lerr) exp_err++;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive nhigh frame cycles (extra cycles carry random data), then one low cycle.
  task automatic send(input logic [SS+15:0] bits, input int nhigh, input bit chk_lat);
    for (int i = 0; i < nhigh; i++) begin
      pdw_frame = 1'b1;
      pdw_data  = (i < SS+16) ? bits[i] : 1'($urandom);
      @(posedge clk); #1;
    end
    if (chk_lat) check_eq("lat_early", SS'(ss_valid), SS'(0));
    pdw_frame = 1'b0;
    pdw_data  = 1'b0;
    @(posedge clk); #1;
    if (chk_lat) check_eq("lat_valid", SS'(ss_valid), SS'(1));
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_good_cnt"}, SS'(good_cnt), STATS ? SS'(exp_good) : SS'(0));
    check_eq({tag, "_err_cnt"},  SS'(err_cnt),  STATS ? SS'(exp_err)  : SS'(0));
  endtask

  // Scoreboard: every output event pops one expectation.
  always @(negedge clk) begin
    if (rst && (ss_valid || len_err)) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_event", SS'({ss_valid, len_err}), SS'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("ss_valid", SS'(ss_valid), SS'(e.valid));
        check_eq("len_err",  SS'(len_err),  SS'(e.lerr));
        check_eq("ss_buff",  ss_buff,       e.buff);
        check_eq("crc_ok",   SS'(crc_ok),   SS'(e.ok));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SS-1:0]   pa, pb, pc, pd, pe, pf, pg;
    logic [SS+15:0]  fr;
    pa = 192'h0000_0001_DEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_A5A5;
    pb = rand_payload();
    pc = rand_payload();
    pd = rand_payload();
    pe = rand_payload();
    pf = rand_payload();
    pg = rand_payload();

    rst = 1'b0; pdw_data = 1'b0; pdw_frame = 1'b0;
    idle(3);
    check_eq("rst_ss_buff",  ss_buff,       SS'(0));
    check_eq("rst_ss_valid", SS'(ss_valid), SS'(0));
    check_eq("rst_crc_ok",   SS'(crc_ok),   SS'(0));
    check_eq("rst_len_err",  SS'(len_err),  SS'(0));
    check_stats("rst");
    rst = 1'b1;
    idle(2);

    // Good frame, then the same frame with received CRC bit 3 flipped.
    expect_out(pa, 1'b1, 1'b1, 1'b0);
    send(mk_frame(pa, 16'h0000), SS+16, 1'b1);
    idle(3); check_stats("good_a");
    expect_out(pa, 1'b0, 1'b1, 1'b0);
    send(mk_frame(pa, 16'h0008), SS+16, 1'b1);
    idle(3); check_stats("bad_crc");

    // Short frame then a good one.
    expect_out(pb, 1'b0, 1'b0, 1'b1);
    send(mk_frame(pb, 16'h0000), 100, 1'b0);
    idle(3); check_stats("short");
    expect_out(pb, 1'b1, 1'b1, 1'b0);
    send(mk_frame(pb, 16'h0000), SS+16, 1'b1);
    idle(3);

    // Overlong frame (210 cycles) then a good one.
    expect_out(pc, 1'b1, 1'b1, 1'b1);
    send(mk_frame(pc, 16'h0000), 210, 1'b0);
    idle(3); check_stats("overlong");
    expect_out(pd, 1'b1, 1'b1, 1'b0);
    send(mk_frame(pd, 16'h0000), SS+16, 1'b1);
    idle(3);
    check_eq("sb_drained_pre_rst", SS'(sb.size()), SS'(0));

    // Reset at bit 50, released while the frame is still high.
    fr = mk_frame(pe, 16'h0000);
    for (int i = 0; i < 50; i++) begin
      pdw_frame = 1'b1; pdw_data = fr[i];
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check_eq("mid_rst_ss_buff",  ss_buff,       SS'(0));
    check_eq("mid_rst_ss_valid", SS'(ss_valid), SS'(0));
    check_eq("mid_rst_crc_ok",   SS'(crc_ok),   SS'(0));
    check_eq("mid_rst_len_err",  SS'(len_err),  SS'(0));
    check_eq("mid_rst_good_cnt", SS'(good_cnt), SS'(0));
    check_eq("mid_rst_err_cnt",  SS'(err_cnt),  SS'(0));
    last_buff = '0; last_ok = 1'b0; exp_good = 0; exp_err = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 50; i < SS+16; i++) begin
      pdw_frame = 1'b1; pdw_data = fr[i];
      @(posedge clk); #1;
    end
    pdw_frame = 1'b0;
    idle(4);
    check_stats("post_rst");
    expect_out(pe, 1'b1, 1'b1, 1'b0);
    send(mk_frame(pe, 16'h0000), SS+16, 1'b1);
    idle(3);

    // Back-to-back frames separated by a single low cycle.
    expect_out(pf, 1'b1, 1'b1, 1'b0);
    expect_out(pg, 1'b1, 1'b1, 1'b0);
    send(mk_frame(pf, 16'h0000), SS+16, 1'b1);
    send(mk_frame(pg, 16'h0000), SS+16, 1'b1);
    idle(5);
    check_stats("b2b");
    check_eq("sb_drained_end", SS'(sb.size()), SS'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
